// File: rtl/ddr3_rw_arbiter.sv
// -----------------------------------------------------------------------------
// ddr3_rw_arbiter
//
// Grants the shared DDR3 AXI4 port to either the write engine (FIFO->AXI burst
// writer) or the read engine (AXI->FIFO burst reader), one whole burst at a
// time. Writes win by default so the write FIFO keeps draining. A starvation
// counter forces a read grant after RD_STARVE_LIMIT write grants taken while a
// read was waiting. A watchdog releases a grant whose engine never reports
// completion.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   arb_en        1 = new grants may be issued
//   wr_req        write engine has a burst ready (level)
//   rd_req        read engine wants a burst (level)
//   wr_done       1-cycle pulse: write burst response accepted
//   rd_done       1-cycle pulse: read burst last beat accepted
//   wr_grant      write engine owns the port (registered level)
//   rd_grant      read engine owns the port (registered level)
//   busy          1 while a grant is held
//   timeout_err   1-cycle pulse when the watchdog releases a grant
//   wr_grant_cnt  write grants issued, wraps
//   rd_grant_cnt  read grants issued, wraps
// -----------------------------------------------------------------------------
module ddr3_rw_arbiter #(
    parameter int RD_STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYCLES  = 4096,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arb_en,
    input  logic                 wr_req,
    input  logic                 rd_req,
    input  logic                 wr_done,
    input  logic                 rd_done,
    output logic                 wr_grant,
    output logic                 rd_grant,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [CNT_WIDTH-1:0] wr_grant_cnt,
    output logic [CNT_WIDTH-1:0] rd_grant_cnt
);

    // Watchdog counts 0..TIMEOUT_CYCLES-1 while a grant is held.
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Starvation counter saturates at RD_STARVE_LIMIT.
    localparam int SC_W = (RD_STARVE_LIMIT > 1) ? $clog2(RD_STARVE_LIMIT + 1) : 1;

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(RD_STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t          state_r;
    logic [WD_W-1:0] wd_cnt_r;
    logic [SC_W-1:0] starve_cnt_r;

    logic starved_s;
    logic pick_rd_s;
    logic pick_wr_s;
    logic cur_done_s;
    logic wd_expire_s;
    logic release_s;
    logic timeout_s;

    // Saturating increment of the starvation counter; only counts a write
    // grant that was taken while a read was waiting.
    function automatic logic [SC_W-1:0] starve_next(input logic [SC_W-1:0] cnt,
                                                    input logic            rd_waiting);
        logic [SC_W-1:0] nxt;
        if (rd_waiting && (cnt < SC_MAX)) begin
            nxt = cnt + SC_W'(1);
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction

    // Arbitration decision, evaluated only when the port is free (IDLE/GAP).
    always_comb begin
        starved_s = (starve_cnt_r >= SC_MAX);
        pick_rd_s = 1'b0;
        pick_wr_s = 1'b0;
        if (arb_en) begin
            if (rd_req && (!wr_req || starved_s)) begin
                pick_rd_s = 1'b1;
            end else if (wr_req) begin
                pick_wr_s = 1'b1;
            end else begin
                pick_rd_s = 1'b0;
                pick_wr_s = 1'b0;
            end
        end else begin
            pick_rd_s = 1'b0;
            pick_wr_s = 1'b0;
        end
    end

    // Release decision for the current owner; a done arriving on the watchdog
    // cycle wins, so the release counts as normal completion.
    always_comb begin
        case (state_r)
            S_WR:    cur_done_s = wr_done;
            S_RD:    cur_done_s = rd_done;
            default: cur_done_s = 1'b0;
        endcase
        wd_expire_s = (wd_cnt_r == WD_LAST);
        release_s   = cur_done_s || wd_expire_s;
        timeout_s   = wd_expire_s && !cur_done_s;
    end

    // Arbiter FSM with registered grants, busy, watchdog and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_IDLE;
            wr_grant     <= 1'b0;
            rd_grant     <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            wr_grant_cnt <= {CNT_WIDTH{1'b0}};
            rd_grant_cnt <= {CNT_WIDTH{1'b0}};
            wd_cnt_r     <= {WD_W{1'b0}};
            starve_cnt_r <= {SC_W{1'b0}};
        end else begin
            timeout_err <= 1'b0;
            case (state_r)
                S_IDLE, S_GAP: begin
                    if (pick_rd_s) begin
                        state_r      <= S_RD;
                        rd_grant     <= 1'b1;
                        busy         <= 1'b1;
                        rd_grant_cnt <= rd_grant_cnt + CNT_WIDTH'(1);
                        starve_cnt_r <= {SC_W{1'b0}};
                        wd_cnt_r     <= {WD_W{1'b0}};
                    end else if (pick_wr_s) begin
                        state_r      <= S_WR;
                        wr_grant     <= 1'b1;
                        busy         <= 1'b1;
                        wr_grant_cnt <= wr_grant_cnt + CNT_WIDTH'(1);
                        starve_cnt_r <= starve_next(starve_cnt_r, rd_req);
                        wd_cnt_r     <= {WD_W{1'b0}};
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_WR, S_RD: begin
                    if (release_s) begin
                        // One mandatory low cycle in S_GAP before the next grant.
                        state_r     <= S_GAP;
                        wr_grant    <= 1'b0;
                        rd_grant    <= 1'b0;
                        busy        <= 1'b0;
                        timeout_err <= timeout_s;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + WD_W'(1);
                    end
                end
                default: begin
                    state_r  <= S_IDLE;
                    wr_grant <= 1'b0;
                    rd_grant <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
